// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default widths, bubble encoding and the
// M/W payload field layout used when packing stage-register buses.
package pipe_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_CNT_W  = 16;
    localparam int unsigned WORD_W         = 32;

    // All-zero instruction word decodes as a NOP.
    localparam logic [WORD_W-1:0] BUBBLE = '0;

    localparam int unsigned MW_GRFWE_LSB = 0;
    localparam int unsigned MW_DM_LSB    = MW_GRFWE_LSB + 1;
    localparam int unsigned MW_ALU_LSB   = MW_DM_LSB  + WORD_W;
    localparam int unsigned MW_PC8_LSB   = MW_ALU_LSB + WORD_W;
    localparam int unsigned MW_PC4_LSB   = MW_PC8_LSB + WORD_W;
    localparam int unsigned MW_PC_LSB    = MW_PC4_LSB + WORD_W;
    localparam int unsigned MW_IR_LSB    = MW_PC_LSB  + WORD_W;
    localparam int unsigned MW_W         = MW_IR_LSB  + WORD_W;

    // Field order matches the LSB offsets above (first member is most significant).
    typedef struct packed {
        logic [WORD_W-1:0] ir;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] pc8;
        logic [WORD_W-1:0] alu;
        logic [WORD_W-1:0] dm;
        logic              grfwe;
    } mw_payload_t;

    function automatic logic [MW_W-1:0] pack_mw(input mw_payload_t p);
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment);
// shared by the pipeline performance counters.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer: in_ready comes straight
// from a flop, so downstream stalls never reach upstream combinationally.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned            DATA_W    = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0]      RESET_VAL = '0,
    parameter int unsigned            CNT_W     = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & ~skid_v_q;
    assign out_fire = main_v_q & out_ready;

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = RESET_VAL;
            skid_v_d = 1'b0;
            skid_d_d = RESET_VAL;
        end else if (!main_v_q || out_fire) begin
            // Skid is older than anything upstream, so it refills main first.
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d_d = skid_d_q;
                skid_v_d = 1'b0;
            end else if (in_fire) begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end else begin
                main_v_d = 1'b0;
                main_d_d = RESET_VAL;
            end
        end else if (in_fire) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v_q <= 1'b0;
            main_d_q <= RESET_VAL;
            skid_v_q <= 1'b0;
            skid_d_q <= RESET_VAL;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign in_ready  = ~skid_v_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (main_v_q & ~out_ready),
        .clr_i  (stall_clr),
        .cnt_o  (stall_cnt)
    );

`ifndef SYNTHESIS
    a_occ_max: assert property (@(posedge clk) disable iff (!reset) occupancy <= 2'd2);
    a_skid_needs_main: assert property (@(posedge clk) disable iff (!reset) skid_v_q |-> main_v_q);
`endif

endmodule
